// File: rtl/seg_pkg.sv
// seg_pkg: shared scan FSM encoding and display-off constants
package seg_pkg;
  typedef enum logic {DRIVE, GUARD} state_t;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display data/control inputs and multiplexed drive outputs
interface seg_scan_ctrl_if;
  logic [15:0] value;
  logic load;
  logic [3:0] blank;
  logic [3:0] blink_en;
  logic [3:0] dp;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp_n;
  logic pending;
  logic frame_done;
  modport master (output value, load, blank, blink_en, dp, input an, seg, dp_n, pending, frame_done);
  modport slave (input value, load, blank, blink_en, dp, output an, seg, dp_n, pending, frame_done);
endinterface

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: hex nibble to active-low {g,f,e,d,c,b,a} glyph
module bcd_to_7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scanner with guard gaps, blink and tear-free frame updates
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input logic clk,
  input logic rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV > GUARD_CYC ? REFRESH_DIV : GUARD_CYC) + 1;
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  state_t st, st_nx;
  logic [1:0] idx, idx_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [FW-1:0] fcnt;
  logic primed, phase, pending, fd, frame_end, blink_now, dark, dp_q;
  logic [15:0] shadow, active, disp;
  logic [3:0] nib, an_q;
  logic [6:0] glyph, seg_q;
  always_comb begin
    st_nx = st;
    idx_nx = idx;
    cnt_nx = cnt + 1'b1;
    if (st == DRIVE && cnt == CW'(REFRESH_DIV - 1)) begin
      st_nx = GUARD;
      cnt_nx = '0;
    end else if (st == GUARD && cnt == CW'(GUARD_CYC - 1)) begin
      st_nx = DRIVE;
      cnt_nx = '0;
      idx_nx = idx + 2'd1;
    end
  end
  // the guard right after reset is not a real frame end, so primed masks it
  assign frame_end = st == GUARD && idx == 2'd3 && cnt == CW'(GUARD_CYC - 1) && primed;
  // digit 0 of a new frame is decoded on the transfer edge, so bypass the pending shadow/phase
  assign disp = fd && pending ? shadow : active;
  assign blink_now = phase ^ (fd && fcnt == FW'(BLINK_FRAMES - 1));
  assign nib = disp[{idx, 2'b00} +: 4];
  assign dark = st == GUARD || bus.blank[idx] || (bus.blink_en[idx] && blink_now);
  bcd_to_7seg u_dec (.nib(nib), .seg(glyph));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= GUARD;
      idx <= 2'd3;
      cnt <= '0;
      fcnt <= '0;
      primed <= 1'b0;
      phase <= 1'b0;
      pending <= 1'b0;
      fd <= 1'b0;
      shadow <= '0;
      active <= '0;
      an_q <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q <= 1'b1;
    end else begin
      st <= st_nx;
      idx <= idx_nx;
      cnt <= cnt_nx;
      primed <= primed | (st == DRIVE);
      fd <= frame_end;
      if (fd && pending) active <= shadow;
      if (bus.load) shadow <= bus.value;
      pending <= bus.load | (pending & ~fd);
      if (fd) begin
        fcnt <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
        phase <= blink_now;
      end
      an_q <= st == DRIVE ? ~(4'b0001 << idx) : AN_OFF;
      seg_q <= dark ? SEG_OFF : glyph;
      dp_q <= dark | ~bus.dp[idx];
    end
  end
  assign bus.an = an_q;
  assign bus.seg = seg_q;
  assign bus.dp_n = dp_q;
  assign bus.pending = pending;
  assign bus.frame_done = fd;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random stimulus against a frame-arithmetic display model
module tb_seg_scan_ctrl;
  localparam int RD = 4, GC = 1, BF = 2, P = RD + GC, FRAME = 4 * P;
  logic clk = 0, rst_n = 0;
  seg_scan_ctrl_if bus ();
  seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD_CYC(GC), .BLINK_FRAMES(BF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int n = 0, errors = 0, checks = 0, fcnt = 0;
  logic [15:0] act = 0, sh = 0;
  bit pend = 0, ph = 0, efd = 0, seen79 = 0;
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask
  // n = clock edges since the last reset edge; outputs trail the scan position by one edge
  task automatic tick();
    int j, d;
    bit g, dk;
    logic [3:0] ean;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      n = 0; act = 0; sh = 0; pend = 0; fcnt = 0; ph = 0;
    end else begin
      n++;
      if (efd && pend) act = sh;
      pend = bus.load || (pend && !efd);
      if (bus.load) sh = bus.value;
      if (efd) begin
        fcnt++;
        if (fcnt == BF) begin fcnt = 0; ph = !ph; end
      end
    end
    j = n < 2 ? 0 : (n - 2) % FRAME;
    d = j / P;
    g = n < 2 || j % P >= RD;
    dk = g || bus.blank[d] || (bus.blink_en[d] && ph);
    ean = 4'hF;
    if (!g) ean[d] = 1'b0;
    efd = n >= FRAME + 1 && (n - 1) % FRAME == 0;
    if (bus.seg == 7'h79) seen79 = 1;
    chk("an", bus.an, ean);
    chk("seg", bus.seg, dk ? 7'h7F : gl[act[4*d +: 4]]);
    chk("dp_n", bus.dp_n, dk || !bus.dp[d]);
    chk("pending", bus.pending, pend);
    chk("frame_done", bus.frame_done, efd);
  endtask
  task automatic wait_fd();
    bit got = 0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      tick();
      got = bus.frame_done;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL wait_fd n=%0d got=0 exp=1", n);
    end
  endtask
  initial begin
    bus.value = 0; bus.load = 0; bus.blank = 0; bus.blink_en = 0; bus.dp = 0;
    tick(); tick();
    chk("rst_an", bus.an, 4'hF);
    chk("rst_seg", bus.seg, 7'h7F);
    rst_n = 1;
    tick();
    bus.value = 16'h1234; bus.load = 1;
    tick();
    bus.load = 0;
    chk("pend_1234", bus.pending, 1);
    wait_fd();
    tick(); chk("d0_1234", bus.seg, 7'h19); chk("an_d0", bus.an, 4'b1110);
    repeat (P) tick(); chk("d1_1234", bus.seg, 7'h30); chk("an_d1", bus.an, 4'b1101);
    repeat (P) tick(); chk("d2_1234", bus.seg, 7'h24);
    repeat (P) tick(); chk("d3_1234", bus.seg, 7'h79); chk("an_d3", bus.an, 4'b0111);
    wait_fd();
    repeat (P + 1) tick();
    bus.value = 16'hABCD; bus.load = 1;
    tick();
    bus.load = 0;
    repeat (P - 1) tick(); chk("d2_old", bus.seg, 7'h24);
    wait_fd();
    tick(); chk("d0_abcd", bus.seg, 7'h21);
    repeat (P) tick(); chk("d1_abcd", bus.seg, 7'h46);
    repeat (P) tick(); chk("d2_abcd", bus.seg, 7'h03);
    repeat (P) tick(); chk("d3_abcd", bus.seg, 7'h08);
    wait_fd();
    seen79 = 0;
    repeat (2) tick();
    bus.value = 16'h1111; bus.load = 1;
    tick();
    bus.load = 0;
    repeat (3) tick();
    bus.value = 16'h2222; bus.load = 1;
    tick();
    bus.load = 0;
    wait_fd();
    tick(); chk("d0_2222", bus.seg, 7'h24);
    repeat (FRAME - 1) tick();
    chk("no_1111", seen79, 0);
    rst_n = 0;
    tick();
    rst_n = 1; bus.blink_en = 4'b0001; bus.blank = 4'b1000;
    while (n < 6 * FRAME + 2) begin
      tick();
      if (n == 2) chk("blink_f0", bus.seg, 7'h40);
      if (n == 2 + 3 * P) begin chk("blank_an3", bus.an, 4'b0111); chk("blank_seg3", bus.seg, 7'h7F); end
      if (n == 2 + 2 * FRAME) begin chk("blink_f2", bus.seg, 7'h7F); chk("blink_an0", bus.an, 4'b1110); end
      if (n == 2 + 4 * FRAME) chk("blink_f4", bus.seg, 7'h40);
    end
    bus.blink_en = 0; bus.blank = 0; bus.dp = 4'b0101;
    wait_fd();
    repeat (2 * P + 1) tick();
    bus.value = 16'h9999; bus.load = 1;
    tick();
    bus.load = 0;
    chk("pend_9999", bus.pending, 1);
    rst_n = 0;
    tick();
    chk("abort_an", bus.an, 4'hF);
    chk("abort_pend", bus.pending, 0);
    rst_n = 1;
    tick(); tick();
    chk("restart_seg", bus.seg, 7'h40);
    chk("restart_an", bus.an, 4'b1110);
    chk("restart_dp", bus.dp_n, 0);
    repeat (600) begin
      bus.load = $urandom_range(7) == 0;
      bus.value = 16'($urandom);
      if ($urandom_range(15) == 0) bus.blank = 4'($urandom);
      if ($urandom_range(15) == 0) bus.blink_en = 4'($urandom);
      if ($urandom_range(7) == 0) bus.dp = 4'($urandom);
      rst_n = $urandom_range(199) != 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit is driven (1 kHz per digit at 100 MHz); SHALL be >= 2.
REQ-002 Parameter GUARD_CYC, default 1000, clk cycles with all anodes off between digits (anti-ghosting); SHALL be >= 1.
REQ-003 Parameter BLINK_FRAMES, default 125, full frames per blink half-period.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 value  input  16  four BCD/hex nibbles; nibble 0 (bits 3:0) is digit 0, the rightmost.
REQ-007 load  input  1  single-cycle strobe; captures value into the shadow register.
REQ-008 blank  input  4  per-digit blank; 1 forces all segments and dp off for that digit.
REQ-009 blink_en  input  4  per-digit blink enable.
REQ-010 dp  input  4  per-digit decimal point, active-high request.
REQ-011 an  output  4  active-low anode enables.
REQ-012 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-013 dp_n  output  1  active-low decimal point.
REQ-014 pending  output  1  high while the shadow holds a value not yet displayed.
REQ-015 frame_done  output  1  one-cycle pulse at the end of each digit-3 guard interval.

Function
REQ-016 FSM states: DRIVE (one anode low) and GUARD (an=4'b1111, seg=7'h7F, dp_n=1); a 2-bit digit index selects the digit.
REQ-017 DRIVE SHALL last exactly REFRESH_DIV cycles, then go to GUARD; GUARD SHALL last exactly GUARD_CYC cycles, then go to DRIVE with the index incremented mod 4 (3 wraps to 0).
REQ-018 In DRIVE, an SHALL be low only at bit [index]; seg SHALL be the hex decode of active nibble [index] (0-F, standard glyphs); dp_n = ~dp[index].
REQ-019 The digit SHALL be dark (seg=7'h7F, dp_n=1, anode still driven) when blank[index]=1, or when blink_en[index]=1 and the blink phase is 1.
REQ-020 The blink phase SHALL toggle after every BLINK_FRAMES frame_done pulses; frame counter wraps to 0 at the toggle.
REQ-021 load=1 SHALL copy value into shadow and set pending=1 on the next edge; a load while pending already set overwrites the shadow (latest wins).
REQ-022 On the cycle frame_done is asserted, if pending=1 the shadow SHALL be copied to the active register and pending cleared on that edge, so digits 0-3 of the next frame all show the new value (no tearing).
REQ-023 load coinciding with the frame_done cycle: the frame_done transfer uses the old shadow and the new value is captured with pending remaining 1 for the following frame.
REQ-024 blank, blink_en and dp are sampled live each cycle (not shadowed).
REQ-025 All outputs SHALL be registered; changes to an/seg/dp_n appear one clk after the state/index change, and an and seg change on the same edge.

Reset
REQ-026 With rst_n=0 at a rising edge: state=GUARD, index=3 (so the first DRIVE after reset is digit 0), counters=0, active=16'h0000, shadow=16'h0000, pending=0, blink phase=0, an=4'hF, seg=7'h7F, dp_n=1, frame_done=0.
REQ-027 Reset asserted mid-frame SHALL abort the scan and discard any pending shadow value.

Structure
REQ-028 Shared package seg_pkg SHALL hold the FSM state encoding, the blanked segment constant 7'h7F and the anode-off constant 4'hF.
REQ-029 The nibble-to-segment decode SHALL be the existing bcd_to_7seg sub-module, instantiated once on the muxed nibble; its output is registered in this block.

Verification (bench params: REFRESH_DIV=4, GUARD_CYC=1, BLINK_FRAMES=2)
REQ-030 Reset release, value loaded 16'h1234 -> pending=1 until first frame_done; then an cycles 1110,1111,1101,1111,1011,1111,0111,1111 with seg 7'h79,7'h24,7'h30,7'h19 (for 4,3,2,1 read right-to-left: digit0=4 -> 7'h19, digit1=3 -> 7'h30, digit2=2 -> 7'h24, digit3=1 -> 7'h79), each DRIVE 4 cycles, GUARD 1 cycle, frame_done every 20 cycles.
REQ-031 load 16'hABCD during digit 1 of a frame -> digits 2,3 of that frame still show old value; next frame shows D,C,B,A (7'h21,7'h46,7'h03,7'h08).
REQ-032 Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 displayed; 1111 never appears on seg.
REQ-033 blink_en=4'b0001 -> digit 0 dark for frames 2-3, lit for frames 0-1 and 4-5; other digits always lit; blank=4'b1000 -> digit 3 always dark with an[3] still pulsed.
REQ-034 rst_n=0 for one cycle during digit 2 with pending=1 -> next cycle an=4'hF, pending=0; scan restarts at digit 0 showing 0 (seg 7'h40).
